tx_ffe_driver: RTL

//  Transmit end of the emulated link: produces the symbol stream and the UI-edge event strobe consumed by
//  the channel filter (value input + time_eq_in). Holds the absolute time of the next TX edge and offers it
//  to the time manager. Fires a one-cycle strobe when system time reaches that edge. Applies a 3-tap FFE
//  to +/-1 symbols to produce the registered, signed fixed-point driver value.

---
 rtl/tx_ffe_driver.sv | 112 +++++++++++
 1 files changed

// File: rtl/tx_ffe_driver.sv
// Transmit end of the emulated link: schedules UI edges in absolute time, strobes the filter,
// and drives a registered 3-tap FFE value built from the +/-1 bit history.
//
// state | meaning
// IDLE  | transmitter stopped, no strobes, out holds
// RUN   | edges fire whenever time_curr reaches time_next_tx
module tx_ffe_driver #(
  parameter int TIME_WIDTH = 32,
  parameter int DT_WIDTH   = 14,
  parameter int JIT_WIDTH  = 8,
  parameter int N_TAPS     = 3,
  parameter int TAP_WIDTH  = 10,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [TIME_WIDTH-1:0]       time_curr,
  input  logic [DT_WIDTH-1:0]         ui_period,
  input  logic [JIT_WIDTH-1:0]        jitter,
  input  logic [N_TAPS*TAP_WIDTH-1:0] taps,
  input  logic                        data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic [TIME_WIDTH-1:0]       time_next_tx,
  output logic                        time_eq_out,
  output logic [OUT_WIDTH-1:0]        out,
  output logic                        underflow,
  output logic                        late
);

  localparam int SW    = DT_WIDTH + 1;
  localparam int ACC_W = OUT_WIDTH + $clog2(N_TAPS) + 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic                     tx_edge;
  logic [N_TAPS-1:0]        hist, hist_nxt;
  logic signed [SW-1:0]     ui_s, jit_s, step_raw;
  logic [SW-1:0]            step_u;
  logic signed [TAP_WIDTH-1:0] tap_k;
  logic signed [ACC_W-1:0]  tap_ext, acc;
  logic [OUT_WIDTH-1:0]     ffe_sat;

  always_comb begin
    state_nxt   = state;
    tx_edge     = 1'b0;
    time_eq_out = 1'b0;
    data_ready  = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        tx_edge     = (time_curr >= time_next_tx);
        time_eq_out = tx_edge;
        data_ready  = tx_edge && data_valid;
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Signed step, clamped so a large negative jitter never stalls or rewinds the schedule.
  always_comb begin
    ui_s     = {1'b0, ui_period};
    jit_s    = {{(SW-JIT_WIDTH){jitter[JIT_WIDTH-1]}}, jitter};
    step_raw = ui_s + jit_s;
    if (step_raw[SW-1] || (step_raw == '0)) step_u = {{(SW-1){1'b0}}, 1'b1};
    else                                    step_u = step_raw;
  end

  always_comb begin
    hist_nxt = {hist[N_TAPS-2:0], (data_valid ? data_in : hist[0])};
    acc      = '0;
    tap_k    = '0;
    tap_ext  = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      tap_k   = taps[k*TAP_WIDTH +: TAP_WIDTH];
      tap_ext = {{(ACC_W-TAP_WIDTH){tap_k[TAP_WIDTH-1]}}, tap_k};
      acc     = hist_nxt[k] ? (acc + tap_ext) : (acc - tap_ext);
    end
    if (acc > OUT_MAX)      ffe_sat = OUT_MAX[OUT_WIDTH-1:0];
    else if (acc < OUT_MIN) ffe_sat = OUT_MIN[OUT_WIDTH-1:0];
    else                    ffe_sat = acc[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      time_next_tx <= '0;
      hist         <= '0;
      out          <= '0;
      underflow    <= 1'b0;
      late         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && enable)
        time_next_tx <= time_curr + {{(TIME_WIDTH-DT_WIDTH){1'b0}}, ui_period};
      // Step from the old target rather than time_curr so late edges do not accumulate drift.
      if (tx_edge) begin
        time_next_tx <= time_next_tx + {{(TIME_WIDTH-SW){1'b0}}, step_u};
        hist         <= hist_nxt;
        out          <= ffe_sat;
        if (!data_valid)              underflow <= 1'b1;
        if (time_curr > time_next_tx) late      <= 1'b1;
      end
    end
  end

endmodule
